// File: rtl/axis_downsizer_if.sv
// AXI Stream handshake bundle: tvalid/tready plus tdata.
// The width is a parameter so one interface serves both the wide and narrow sides.
interface axis_downsizer_if #(
  parameter int TDATA_WIDTH = 8
);
  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;

  modport master (
    output tvalid,
    output tdata,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    output tready
  );
endinterface

// File: rtl/axis_downsizer.sv
// AXI Stream width-down converter: one wide word in, RATIO narrow beats out.
// Zero-bubble between words; shares the upstream FIFO flush line.
module axis_downsizer #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  axis_downsizer_if.master  axis_mif,
  axis_downsizer_if.slave   axis_sif,
  input  logic              invalidate
);
  localparam int MW    = $bits(axis_mif.tdata);
  localparam int SW    = $bits(axis_sif.tdata);
  localparam int RATIO = SW / MW;
  localparam int CW    = (RATIO > 2) ? $clog2(RATIO) : 1;

  if ((SW % MW) != 0 || RATIO < 2) begin : g_bad_width
    $fatal(1, "axis_downsizer: SW must be a multiple of MW, RATIO >= 2");
  end

  localparam logic [CW-1:0] LAST_IDX = CW'(RATIO - 1);

  logic [SW-1:0] data_q;
  logic [CW-1:0] cnt_q;
  logic          valid_q;

  logic          last;
  logic          m_hs;
  logic          s_rdy;
  logic          s_hs;
  logic [CW-1:0] sel;
  logic [MW-1:0] beat;

  assign last  = (cnt_q == LAST_IDX);
  assign m_hs  = valid_q && axis_mif.tready;
  assign s_rdy = !rst && !invalidate
               && (!valid_q || (axis_mif.tready && last));
  assign s_hs  = axis_sif.tvalid && s_rdy;

  assign axis_sif.tready = s_rdy;
  assign axis_mif.tvalid = valid_q;

  // Beat order is fixed at elaboration; the mux reads registers only.
  assign sel = LSB_FIRST ? cnt_q : (LAST_IDX - cnt_q);

  always_comb begin
    beat = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (sel == CW'(i)) beat = data_q[i*MW +: MW];
    end
  end

  assign axis_mif.tdata = beat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else if (invalidate) begin
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else if (s_hs) begin
      // Covers both the idle load and the back-to-back reload on the last beat.
      data_q  <= axis_sif.tdata;
      cnt_q   <= '0;
      valid_q <= 1'b1;
    end else if (m_hs) begin
      if (last) begin
        cnt_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        cnt_q   <= cnt_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_axis_downsizer.sv
// Directed bench for axis_downsizer, 32->8, both beat orders.
// Expected beats are queued at stimulus time and popped on each narrow handshake.
module tb_axis_downsizer;
  logic clk;
  logic rst;
  logic invalidate;

  int checks = 0;
  int errors = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  axis_downsizer_if #(.TDATA_WIDTH(8))  m0 ();
  axis_downsizer_if #(.TDATA_WIDTH(32)) s0 ();
  axis_downsizer_if #(.TDATA_WIDTH(8))  m1 ();
  axis_downsizer_if #(.TDATA_WIDTH(32)) s1 ();

  axis_downsizer #(.LSB_FIRST(1'b1)) dut0 (
    .clk        (clk),
    .rst        (rst),
    .axis_mif   (m0),
    .axis_sif   (s0),
    .invalidate (invalidate)
  );

  axis_downsizer #(.LSB_FIRST(1'b0)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .axis_mif   (m1),
    .axis_sif   (s1),
    .invalidate (invalidate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push0(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) q0.push_back(w[i*8 +: 8]);
  endtask

  // Narrow-side scoreboard: a beat seen valid&ready here completes at the next edge.
  always @(negedge clk) begin
    if (!rst && m0.tvalid && m0.tready) begin
      checks++;
      assert (q0.size() != 0) else begin
        errors++;
        $error("FAIL m0_extra observed %h expected none", m0.tdata);
      end
      if (q0.size() != 0) begin
        logic [7:0] e;
        e = q0.pop_front();
        checks++;
        assert (m0.tdata === e) else begin
          errors++;
          $error("FAIL m0_beat observed %h expected %h", m0.tdata, e);
        end
      end
    end
    if (!rst && m1.tvalid && m1.tready) begin
      checks++;
      assert (q1.size() != 0) else begin
        errors++;
        $error("FAIL m1_extra observed %h expected none", m1.tdata);
      end
      if (q1.size() != 0) begin
        logic [7:0] e;
        e = q1.pop_front();
        checks++;
        assert (m1.tdata === e) else begin
          errors++;
          $error("FAIL m1_beat observed %h expected %h", m1.tdata, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    invalidate = 1'b0;
    s0.tvalid = 1'b0;
    s0.tdata = '0;
    m0.tready = 1'b1;
    s1.tvalid = 1'b0;
    s1.tdata = '0;
    m1.tready = 1'b1;

    // Reset state
    #2;
    chk("rst_tvalid", m0.tvalid, 0);
    chk("rst_tdata", m0.tdata, 0);
    chk("rst_tready", s0.tready, 0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    chk("rel_tready", s0.tready, 1);
    cyc();

    // Single word, sink always ready
    s0.tdata = 32'hDDCCBBAA;
    s0.tvalid = 1'b1;
    push0(32'hDDCCBBAA, 4);
    @(negedge clk);
    chk("t1_idle_rdy", s0.tready, 1);
    cyc();
    s0.tvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t1_valid", m0.tvalid, 1);
      chk("t1_srdy", s0.tready, (k == 3));
      if (k == 0) chk("t1_lat", m0.tdata, 32'hAA);
      cyc();
    end
    @(negedge clk);
    chk("t1_done", m0.tvalid, 0);
    chk("t1_q", q0.size(), 0);
    cyc();

    // Back-to-back words
    s0.tdata = 32'h03020100;
    s0.tvalid = 1'b1;
    push0(32'h03020100, 4);
    push0(32'h07060504, 4);
    @(negedge clk);
    cyc();
    s0.tdata = 32'h07060504;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t2_nogap", m0.tvalid, 1);
      if (k < 4) chk("t2_srdy", s0.tready, (k == 3));
      if (k == 3) chk("t2_hs_beat", m0.tdata, 32'h03);
      cyc();
      if (k == 3) s0.tvalid = 1'b0;
    end
    @(negedge clk);
    chk("t2_done", m0.tvalid, 0);
    chk("t2_q", q0.size(), 0);
    cyc();

    // Backpressure at beat 1
    s0.tdata = 32'h44332211;
    s0.tvalid = 1'b1;
    push0(32'h44332211, 4);
    @(negedge clk);
    cyc();
    s0.tvalid = 1'b0;
    @(negedge clk);
    cyc();
    m0.tready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_hold_data", m0.tdata, 32'h22);
      chk("t3_hold_valid", m0.tvalid, 1);
      cyc();
    end
    m0.tready = 1'b1;
    repeat (4) cyc();
    chk("t3_q", q0.size(), 0);

    // MSB-first instance
    s1.tdata = 32'hDDCCBBAA;
    s1.tvalid = 1'b1;
    q1.push_back(8'hDD);
    q1.push_back(8'hCC);
    q1.push_back(8'hBB);
    q1.push_back(8'hAA);
    @(negedge clk);
    cyc();
    s1.tvalid = 1'b0;
    @(negedge clk);
    chk("t4_first", m1.tdata, 32'hDD);
    repeat (5) cyc();
    chk("t4_q", q1.size(), 0);

    // Flush at beat 2: CC delivered, DD dropped
    s0.tdata = 32'hDDCCBBAA;
    s0.tvalid = 1'b1;
    push0(32'hDDCCBBAA, 3);
    @(negedge clk);
    cyc();
    s0.tvalid = 1'b0;
    cyc();
    cyc();
    invalidate = 1'b1;
    @(negedge clk);
    chk("t5_beat2", m0.tdata, 32'hCC);
    chk("t5_srdy", s0.tready, 0);
    cyc();
    invalidate = 1'b0;
    @(negedge clk);
    chk("t5_flushed", m0.tvalid, 0);
    chk("t5_q", q0.size(), 0);
    cyc();

    // Flush while idle blocks a pending word
    invalidate = 1'b1;
    s0.tdata = 32'hEEEEEEEE;
    s0.tvalid = 1'b1;
    @(negedge clk);
    chk("t5_idle_srdy", s0.tready, 0);
    cyc();
    invalidate = 1'b0;
    s0.tvalid = 1'b0;
    @(negedge clk);
    chk("t5_no_load", m0.tvalid, 0);
    cyc();

    // Next word after flush starts at beat 0
    s0.tdata = 32'h03020100;
    s0.tvalid = 1'b1;
    push0(32'h03020100, 4);
    @(negedge clk);
    cyc();
    s0.tvalid = 1'b0;
    @(negedge clk);
    chk("t5_restart", m0.tdata, 32'h00);
    repeat (5) cyc();
    chk("t5_q2", q0.size(), 0);

    // Async reset mid-word
    s0.tdata = 32'h44332211;
    s0.tvalid = 1'b1;
    push0(32'h44332211, 1);
    @(negedge clk);
    cyc();
    s0.tvalid = 1'b0;
    @(negedge clk);
    cyc();
    #2 rst = 1'b1;
    #1;
    chk("t6_async_valid", m0.tvalid, 0);
    chk("t6_async_data", m0.tdata, 0);
    chk("t6_async_srdy", s0.tready, 0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    chk("t6_rel_srdy", s0.tready, 1);
    chk("t6_no_stale", m0.tvalid, 0);
    repeat (3) cyc();
    chk("t6_q", q0.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
